// File: rtl/mac8_arbiter_pkg.sv
// Shared types for the mac8 arbiter: FU op payload, exception record and the
// per-requester request bundle (payload plus chain-end flag).
package mac8_arbiter_pkg;

  localparam int TRANS_ID_BITS      = 3;
  localparam int MAC8_ARB_TAG_DEPTH = 4;

  typedef enum logic [0:0] {
    MAC8_INIT = 1'b0,
    MAC8_ACC  = 1'b1
  } mac8_op_t;

  typedef struct packed {
    mac8_op_t                 operation;
    logic [31:0]              operand_a;
    logic [31:0]              operand_b;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    fu_data_t data;
    logic     last;
  } mac8_arb_req_t;

endpackage

// File: rtl/mac8_tag_fifo.sv
// FIFO of requester IDs for ops in flight in the FU; head names the requester
// that owns the next returning result.
module mac8_tag_fifo
  import mac8_arbiter_pkg::*;
#(
  parameter int DEPTH = MAC8_ARB_TAG_DEPTH,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !full_o;
  assign head_o  = mem[rd_ptr_q];

  // NOTE: storage has no reset; the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mac8_arbiter.sv
// Shares one stateful mac8 FU among NUM_REQ requesters: chains hold ownership
// until their last op, round-robin between chains, results routed by tag.
module mac8_arbiter
  import mac8_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int TAG_DEPTH = MAC8_ARB_TAG_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  fu_data_t                     req_data_i [NUM_REQ],
  input  logic [NUM_REQ-1:0]           req_last_i,
  output logic                         mac_valid_o,
  output fu_data_t                     mac_data_o,
  input  logic                         mac_ready_i,
  input  logic                         mac_valid_i,
  input  logic [31:0]                  mac_result_i,
  input  logic [TRANS_ID_BITS-1:0]     mac_trans_id_i,
  input  exception_t                   mac_exception_i,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  output logic [31:0]                  rsp_result_o,
  output logic [TRANS_ID_BITS-1:0]     rsp_trans_id_o,
  output exception_t                   rsp_exception_o,
  output logic                         locked_o,
  output logic [$clog2(NUM_REQ)-1:0]   owner_o,
  output logic                         err_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [0:0] UNLOCKED = 1'b0;
  localparam logic [0:0] LOCKED   = 1'b1;

  logic [0:0]       state_q;
  logic [IDX_W-1:0] owner_q, rr_q;
  logic             err_q;

  logic             win_found;
  logic [IDX_W-1:0] win_idx, rr_next;
  int               cand;
  mac8_arb_req_t    win_req;
  logic             grant;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [IDX_W-1:0] fifo_head;

  // Scan downward so the lowest offset from rr_q is the last (winning) write.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    if (state_q == LOCKED) begin
      win_found = req_valid_i[owner_q];
      win_idx   = owner_q;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = (int'(rr_q) + k) % NUM_REQ;
        if (req_valid_i[cand]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(cand);
        end
      end
    end
  end

  assign win_req = '{data: req_data_i[win_idx], last: req_last_i[win_idx]};
  // Registered full flag: a pop in the same cycle does not free a slot for grant.
  assign grant   = win_found && mac_ready_i && !fifo_full;
  assign rr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  assign mac_valid_o = grant;
  assign mac_data_o  = win_req.data;

  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[win_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= UNLOCKED;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      if (grant) begin
        if (win_req.last) begin
          state_q <= UNLOCKED;
          rr_q    <= rr_next;
        end else begin
          state_q <= LOCKED;
          owner_q <= win_idx;
        end
      end
      if (flush_i) state_q <= UNLOCKED;
    end
  end

  assign locked_o = (state_q == LOCKED);
  assign owner_o  = owner_q;

  mac8_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (IDX_W)
  ) u_tag_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (grant),
    .push_data_i (win_idx),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign fifo_pop = mac_valid_i && !fifo_empty;

  always_comb begin
    rsp_valid_o = '0;
    if (fifo_pop) rsp_valid_o[fifo_head] = 1'b1;
  end

  assign rsp_result_o    = mac_result_i;
  assign rsp_trans_id_o  = mac_trans_id_i;
  assign rsp_exception_o = mac_exception_i;

  // A result with nothing in flight has no owner; flag it until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                        err_q <= 1'b0;
    else if (mac_valid_i && fifo_empty) err_q <= 1'b1;
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_mac8_arbiter.sv
// Directed bench for mac8_arbiter with two requesters: chain locking,
// round-robin, back-pressure, FIFO full, flush, reset and orphan results.
module tb_mac8_arbiter;
  import mac8_arbiter_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush;
  logic [1:0]               req_valid, req_ready, req_last, rsp_valid;
  fu_data_t                 req_data [2];
  logic                     mac_valid_out, mac_ready, mac_valid_in;
  fu_data_t                 mac_data;
  logic [31:0]              mac_result, rsp_result;
  logic [TRANS_ID_BITS-1:0] mac_trans_id, rsp_trans_id;
  exception_t               mac_exception, rsp_exception;
  logic                     locked, owner, err;

  int pass_cnt = 0;
  int total_cnt = 0;

  mac8_arbiter #(.NUM_REQ(2), .TAG_DEPTH(4)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_data_i      (req_data),
    .req_last_i      (req_last),
    .mac_valid_o     (mac_valid_out),
    .mac_data_o      (mac_data),
    .mac_ready_i     (mac_ready),
    .mac_valid_i     (mac_valid_in),
    .mac_result_i    (mac_result),
    .mac_trans_id_i  (mac_trans_id),
    .mac_exception_i (mac_exception),
    .rsp_valid_o     (rsp_valid),
    .rsp_result_o    (rsp_result),
    .rsp_trans_id_o  (rsp_trans_id),
    .rsp_exception_o (rsp_exception),
    .locked_o        (locked),
    .owner_o         (owner),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input mac8_op_t op, input logic last);
    req_valid[r]          = v;
    req_last[r]           = last;
    req_data[r].operation = op;
    req_data[r].operand_a = 32'h55667788;
    req_data[r].operand_b = 32'h11223344;
    req_data[r].trans_id  = TRANS_ID_BITS'(r + 1);
  endtask

  task automatic test_reset();
    #1;
    total_cnt++;
    if ({req_ready, rsp_valid, mac_valid_out} !== 5'b0)
      $display("FAIL reset_valids: got %b expected 00000", {req_ready, rsp_valid, mac_valid_out});
    else pass_cnt++;
    total_cnt++;
    if ({locked, owner, err} !== 3'b000)
      $display("FAIL reset_state: got %b expected 000", {locked, owner, err});
    else pass_cnt++;
  endtask

  task automatic test_lock_chain();
    logic [1:0] exp [4];
    set_req(0, 1'b1, MAC8_INIT, 1'b0);
    set_req(1, 1'b1, MAC8_ACC, 1'b1);
    #1;
    total_cnt++;
    if ({req_ready, mac_valid_out, locked} !== 4'b0110)
      $display("FAIL chain_first: got %b expected 0110", {req_ready, mac_valid_out, locked});
    else pass_cnt++;
    total_cnt++;
    if (mac_data.operand_a !== 32'h55667788 || mac_data.operation !== MAC8_INIT || mac_data.trans_id !== 3'd1)
      $display("FAIL chain_data: got a=%h op=%0d id=%0d expected a=55667788 op=0 id=1",
               mac_data.operand_a, mac_data.operation, mac_data.trans_id);
    else pass_cnt++;
    tick();
    set_req(0, 1'b1, MAC8_ACC, 1'b0);
    #1;
    total_cnt++;
    if ({req_ready, locked, owner} !== 4'b0110)
      $display("FAIL chain_mid: got %b expected 0110", {req_ready, locked, owner});
    else pass_cnt++;
    tick();
    set_req(0, 1'b1, MAC8_ACC, 1'b1);
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL chain_last: got %b expected 01", req_ready);
    else pass_cnt++;
    tick();
    set_req(0, 1'b0, MAC8_ACC, 1'b0);
    #1;
    total_cnt++;
    if ({req_ready, locked} !== 3'b100)
      $display("FAIL chain_handoff: got %b expected 100", {req_ready, locked});
    else pass_cnt++;
    tick();
    set_req(1, 1'b0, MAC8_ACC, 1'b0);
    exp = '{2'b01, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      mac_valid_in = 1'b1;
      mac_result   = 32'hABCD0000 + i;
      mac_trans_id = TRANS_ID_BITS'(i);
      #1;
      total_cnt++;
      if (rsp_valid !== exp[i] || rsp_result !== 32'hABCD0000 + i || rsp_trans_id !== TRANS_ID_BITS'(i))
        $display("FAIL chain_rsp%0d: got v=%b r=%h expected v=%b r=%h", i, rsp_valid, rsp_result,
                 exp[i], 32'hABCD0000 + i);
      else pass_cnt++;
      tick();
    end
    mac_valid_in = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp [4];
    exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    set_req(0, 1'b1, MAC8_INIT, 1'b1);
    set_req(1, 1'b1, MAC8_INIT, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++;
      if ({req_ready, locked} !== {exp[i], 1'b0})
        $display("FAIL rr_grant%0d: got %b expected %b", i, {req_ready, locked}, {exp[i], 1'b0});
      else pass_cnt++;
      tick();
    end
    set_req(0, 1'b0, MAC8_INIT, 1'b0);
    set_req(1, 1'b0, MAC8_INIT, 1'b0);
    total_cnt++;
    if (locked !== 1'b0) $display("FAIL rr_locked: got %b expected 0", locked);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      mac_valid_in = 1'b1;
      #1;
      total_cnt++;
      if (rsp_valid !== exp[i]) $display("FAIL rr_rsp%0d: got %b expected %b", i, rsp_valid, exp[i]);
      else pass_cnt++;
      tick();
    end
    mac_valid_in = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [1:0] exp [4];
    set_req(0, 1'b1, MAC8_INIT, 1'b0);
    set_req(1, 1'b1, MAC8_ACC, 1'b1);
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL bp_first: got %b expected 01", req_ready);
    else pass_cnt++;
    tick();
    set_req(0, 1'b1, MAC8_ACC, 1'b0);
    mac_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if ({mac_valid_out, req_ready, locked} !== 4'b0001)
        $display("FAIL bp_stall%0d: got %b expected 0001", i, {mac_valid_out, req_ready, locked});
      else pass_cnt++;
      tick();
    end
    mac_ready = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL bp_resume: got %b expected 01", req_ready);
    else pass_cnt++;
    tick();
    set_req(0, 1'b1, MAC8_ACC, 1'b1);
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL bp_last: got %b expected 01", req_ready);
    else pass_cnt++;
    tick();
    set_req(0, 1'b0, MAC8_ACC, 1'b0);
    #1;
    total_cnt++;
    if (req_ready !== 2'b10) $display("FAIL bp_handoff: got %b expected 10", req_ready);
    else pass_cnt++;
    tick();
    set_req(1, 1'b0, MAC8_ACC, 1'b0);
    exp = '{2'b01, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      mac_valid_in = 1'b1;
      #1;
      total_cnt++;
      if (rsp_valid !== exp[i]) $display("FAIL bp_rsp%0d: got %b expected %b", i, rsp_valid, exp[i]);
      else pass_cnt++;
      tick();
    end
    mac_valid_in = 1'b0;
  endtask

  task automatic test_fifo_full();
    set_req(0, 1'b1, MAC8_INIT, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++;
      if (req_ready !== 2'b01) $display("FAIL full_fill%0d: got %b expected 01", i, req_ready);
      else pass_cnt++;
      tick();
    end
    #1;
    total_cnt++;
    if ({req_ready, mac_valid_out} !== 3'b000)
      $display("FAIL full_stall: got %b expected 000", {req_ready, mac_valid_out});
    else pass_cnt++;
    tick();
    mac_valid_in = 1'b1;
    #1;
    total_cnt++;
    if ({req_ready, rsp_valid} !== 4'b0001)
      $display("FAIL full_pop_nogrant: got %b expected 0001", {req_ready, rsp_valid});
    else pass_cnt++;
    tick();
    mac_valid_in = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL full_regrant: got %b expected 01", req_ready);
    else pass_cnt++;
    tick();
    set_req(0, 1'b0, MAC8_INIT, 1'b0);
    for (int i = 0; i < 4; i++) begin
      mac_valid_in = 1'b1;
      #1;
      total_cnt++;
      if (rsp_valid !== 2'b01) $display("FAIL full_rsp%0d: got %b expected 01", i, rsp_valid);
      else pass_cnt++;
      tick();
    end
    mac_valid_in = 1'b0;
  endtask

  task automatic test_flush();
    logic [1:0] exp [3];
    set_req(0, 1'b1, MAC8_INIT, 1'b0);
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL flush_first: got %b expected 01", req_ready);
    else pass_cnt++;
    tick();
    set_req(0, 1'b1, MAC8_ACC, 1'b0);
    set_req(1, 1'b1, MAC8_INIT, 1'b1);
    flush = 1'b1;
    #1;
    total_cnt++;
    if ({req_ready, locked} !== 3'b011)
      $display("FAIL flush_same_cycle: got %b expected 011", {req_ready, locked});
    else pass_cnt++;
    tick();
    flush = 1'b0;
    set_req(0, 1'b0, MAC8_ACC, 1'b0);
    #1;
    total_cnt++;
    if ({req_ready, locked} !== 3'b100)
      $display("FAIL flush_after: got %b expected 100", {req_ready, locked});
    else pass_cnt++;
    tick();
    set_req(1, 1'b0, MAC8_INIT, 1'b0);
    exp = '{2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 3; i++) begin
      mac_valid_in = 1'b1;
      #1;
      total_cnt++;
      if (rsp_valid !== exp[i]) $display("FAIL flush_rsp%0d: got %b expected %b", i, rsp_valid, exp[i]);
      else pass_cnt++;
      tick();
    end
    mac_valid_in = 1'b0;
  endtask

  task automatic test_reset_mid_chain();
    set_req(0, 1'b1, MAC8_INIT, 1'b0);
    tick();
    set_req(0, 1'b0, MAC8_INIT, 1'b0);
    total_cnt++;
    if (locked !== 1'b1) $display("FAIL midrst_locked: got %b expected 1", locked);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({locked, owner} !== 2'b00) $display("FAIL midrst_cleared: got %b expected 00", {locked, owner});
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_orphan_result();
    mac_valid_in = 1'b1;
    #1;
    total_cnt++;
    if ({rsp_valid, err} !== 3'b000)
      $display("FAIL orphan_drop: got %b expected 000", {rsp_valid, err});
    else pass_cnt++;
    tick();
    mac_valid_in = 1'b0;
    total_cnt++;
    if (err !== 1'b1) $display("FAIL orphan_err: got %b expected 1", err);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (err !== 1'b1) $display("FAIL orphan_sticky: got %b expected 1", err);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (err !== 1'b0) $display("FAIL orphan_reset: got %b expected 0", err);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    mac_ready     = 1'b1;
    mac_valid_in  = 1'b0;
    mac_result    = '0;
    mac_trans_id  = '0;
    mac_exception = '0;
    req_valid     = '0;
    req_last      = '0;
    set_req(0, 1'b0, MAC8_INIT, 1'b0);
    set_req(1, 1'b0, MAC8_INIT, 1'b0);
    repeat (2) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_lock_chain();
    test_round_robin();
    test_backpressure();
    test_fifo_full();
    test_flush();
    test_reset_mid_chain();
    test_orphan_result();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
